// File: rtl/adc_uart_reporter_pkg.sv
// Shared constants, FSM state encoding and ASCII helpers for the ADC level reporter.
// Level thresholds are the lower bound of each letter band.
package adc_report_pkg;

  localparam logic [7:0] LVL_B_MIN = 8'h0B;
  localparam logic [7:0] LVL_C_MIN = 8'h1D;
  localparam logic [7:0] LVL_D_MIN = 8'h35;
  localparam logic [7:0] LVL_E_MIN = 8'h67;
  localparam logic [7:0] LVL_F_MIN = 8'h9B;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_0     = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_NEXT  = 3'd5
  } fsm_state_e;

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_STOP  = ST_STOP;
  localparam logic [2:0] S_NEXT  = ST_NEXT;

  function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'd0, n};
    else           return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] level_ascii(input logic [7:0] avg);
    if      (avg >= LVL_F_MIN) return ASCII_A + 8'd5;
    else if (avg >= LVL_E_MIN) return ASCII_A + 8'd4;
    else if (avg >= LVL_D_MIN) return ASCII_A + 8'd3;
    else if (avg >= LVL_C_MIN) return ASCII_A + 8'd2;
    else if (avg >= LVL_B_MIN) return ASCII_A + 8'd1;
    else                       return ASCII_A;
  endfunction

endpackage

// File: rtl/adc_uart_reporter_if.sv
// Sample stream from the ADC capture stage: one-cycle valid strobe with 8-bit data.
interface adc_uart_reporter_if;
  logic [7:0] sample_data;
  logic       sample_valid;

  modport master (output sample_data, output sample_valid);
  modport slave  (input  sample_data, input  sample_valid);
endinterface

// File: rtl/adc_uart_reporter_uart_tx.sv
// 8N1 serialiser: one byte per tx_start, tx_done pulses in the final stop-bit cycle.
//   state   | meaning
//   IDLE    | line high, waiting for tx_start
//   START   | start bit (low) for CLKS_PER_BIT cycles
//   DATA    | 8 data bits LSB first, CLKS_PER_BIT cycles each
//   STOP    | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_8n1
  import adc_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       UART_TX
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          timer_tc;

  assign timer_tc = (timer_q == '0);
  assign tx_done  = (state_q == S_STOP) && timer_tc;
  assign UART_TX  = tx_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shreg_d = tx_byte;
          timer_d = BIT_RELOAD;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_tc) begin
          timer_d = BIT_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (timer_tc) begin
          timer_d = BIT_RELOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Shift first so the next bit is always at shreg_q[1] here.
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (timer_tc) state_d = S_IDLE;
        else          timer_d = timer_q - 1'b1;
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/adc_uart_reporter.sv
// Box-car averages ADC samples and reports each average as "L HH\r\n" over 8N1 UART.
//   state   | meaning
//   IDLE    | no frame in progress
//   LOAD    | hand current byte to the serialiser
//   START   | serialiser busy with the byte, waiting for tx_done
//   NEXT    | advance byte index, or chain the pending result, or finish
module adc_uart_reporter
  import adc_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned AVG_LOG2     = 4
) (
  input  logic                CLK,
  input  logic                RST,
  adc_uart_reporter_if.slave  smp,
  output logic                UART_TX,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned AW = 8 + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    avg;
  logic          avg_done;

  logic [2:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] slot_q, slot_d;
  logic       slot_full_q, slot_full_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;

  logic       avail, frame_end, start_frame, tx_start, tx_done;
  logic [7:0] src, tx_byte;

  assign sum      = acc_q + AW'(smp.sample_data);
  assign avg      = 8'(sum >> AVG_LOG2);
  assign avg_done = smp.sample_valid && (cnt_q == CNT_LAST);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (smp.sample_valid) begin
      if (avg_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A pending slot always wins over a same-cycle average, which then takes the slot.
  assign avail       = slot_full_q || avg_done;
  assign src         = slot_full_q ? slot_q : avg;
  assign frame_end   = (state_q == S_NEXT) && (idx_q == 3'd5);
  assign start_frame = ((state_q == S_IDLE) || frame_end) && avail;
  assign tx_start    = (state_q == S_LOAD);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    overrun_d   = overrun_q;
    case (state_q)
      S_IDLE:  if (avail) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (tx_done) state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q != 3'd5) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end else if (avail) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      frame_d     = src;
      idx_d       = 3'd0;
      slot_full_d = slot_full_q && avg_done;
      if (slot_full_q && avg_done) slot_d = avg;
    end else if (avg_done) begin
      slot_d      = avg;
      slot_full_d = 1'b1;
      if (slot_full_q) overrun_d = 1'b1;
    end

    busy_d = busy_q;
    if (state_q == S_LOAD)  busy_d = 1'b1;
    if (state_d == S_IDLE)  busy_d = 1'b0;
  end

  always_comb begin
    case (idx_q)
      3'd0:    tx_byte = level_ascii(frame_q);
      3'd1:    tx_byte = ASCII_SPACE;
      3'd2:    tx_byte = nibble_ascii(frame_q[7:4]);
      3'd3:    tx_byte = nibble_ascii(frame_q[3:0]);
      3'd4:    tx_byte = ASCII_CR;
      default: tx_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLK      (CLK),
    .RST      (RST),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done),
    .UART_TX  (UART_TX)
  );

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: doc/adc_uart_reporter.md
# adc_uart_reporter

Consumes the 8-bit sample stream produced by the AD9283 capture stage. Box-car averages a fixed power-of-two number of samples and maps the average to a coarse level letter A–F. Transmits each result as a 6-byte ASCII frame on an 8N1 UART TX line for host monitoring. Sits directly downstream of the ADC capture block on the same system clock.

## Interface
- `CLKS_PER_BIT`, default 868: CLK cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- `AVG_LOG2`, default 4: log2 of samples per average. Legal range 0–8.
- `CLK` input, 1 bit: system clock. All logic on rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset. Assertion is asynchronous; deassertion is synchronised externally.
- `sample_data` input, 8 bits: unsigned ADC sample.
- `sample_valid` input, 1 bit: one-CLK strobe; `sample_data` is valid in that cycle.
- `UART_TX` output, 1 bit: serial line, idle high.
- `busy` output, 1 bit: high while a frame is being transmitted.
- `overrun` output, 1 bit: sticky flag; cleared only by `RST`.

## Operation
- **Accumulator**
  - Width 8+AVG_LOG2 bits, plus an AVG_LOG2-bit sample counter.
  - On each `sample_valid`: add the sample and increment the counter.
  - On the 2^AVG_LOG2-th sample, the average is (sum including this sample) >> AVG_LOG2, truncated.
  - The average is written to the result register, the accumulator and counter clear, and accumulation restarts with the next strobe. No sample is dropped across the boundary.
- **Level map** (on the average)
  - F: 0x9B–0xFF
  - E: 0x67–0x9A
  - D: 0x35–0x66
  - C: 0x1D–0x34
  - B: 0x0B–0x1C
  - A: 0x00–0x0A
- **Frame**: 6 bytes in order: level letter, 0x20, hex high nibble, hex low nibble, 0x0D, 0x0A. Hex digits are uppercase ASCII ('0'–'9', 'A'–'F').
- **Buffering**: one pending-result slot.
  - A new average with the slot empty and TX idle: the frame starts.
  - A new average with TX busy: the result goes into the pending slot.
  - A new average with TX busy and the slot full: the newer value overwrites the slot and `overrun` sets.
  - At frame end, if the slot is full, the next frame starts from the slot.
- **FSM states**: IDLE, LOAD, START, DATA, STOP, NEXT.
  - IDLE→LOAD: a result is available.
  - LOAD: latch the byte, then go to START.
  - START: hold low for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits, LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: hold high for CLKS_PER_BIT cycles, then go to NEXT.
  - NEXT: if the byte index < 5, increment it and go to LOAD. Otherwise go to IDLE, or to LOAD with index 0 if the slot is full.
- **Reset values**
  - Outputs: `UART_TX`=1, `busy`=0, `overrun`=0.
  - Internal: accumulator, counter, slot and byte index all 0.
  - Reset mid-frame aborts the frame immediately; `UART_TX` goes high asynchronously.

## Timing
- Average registered 1 CLK after the final `sample_valid`.
- `busy` rises and the start bit begins 2 CLK after the final `sample_valid`: 1 cycle for the average, 1 cycle for LOAD.
- Each byte occupies exactly 10·CLKS_PER_BIT + 2 CLK: LOAD and NEXT each add 1 idle-high cycle between bytes.
- `busy` falls the cycle the FSM enters IDLE.
- A pending frame starts with no extra gap beyond NEXT→LOAD.
- A `sample_valid` in the same cycle as a frame completion is accepted. Accumulation never stalls.

## Structure
- **Package `adc_report_pkg`** holds:
  - the level threshold constants (0x0B, 0x1D, 0x35, 0x67, 0x9B)
  - the ASCII constants (space, CR, LF, 'A')
  - the FSM state enum
  - a nibble-to-ASCII function
- **Sub-module `uart_tx_8n1`** (parameter CLKS_PER_BIT)
  - Inputs: `tx_start` and an 8-bit `tx_byte`.
  - Outputs: `tx_done` (one-cycle pulse) and `UART_TX`.
  - It owns the bit timer and the START/DATA/STOP sequencing.
  - The top level owns the accumulator, the pending slot and the byte sequencing.

## Test plan
All scenarios use CLKS_PER_BIT=4 and AVG_LOG2=2 unless stated.
1. Reset: assert `RST` mid-frame → `UART_TX`=1 in the same cycle; `busy`=0 and `overrun`=0. After release, 4 strobes of 0x20 → frame "C 20\r\n".
2. Averaging: strobes 0x00, 0x01, 0x02, 0x04 → average 0x01 (truncated), frame "A 01\r\n". Decoded bit cells are 4 CLK wide, LSB first.
3. Thresholds: averages 0x0A, 0x0B, 0x1C, 0x1D, 0x9A, 0x9B, 0xFF → letters A, B, B, C, E, F, F.
4. Back-to-back: a second average completes during a frame → it is sent immediately after the first LF with a 2-CLK gap; `overrun` stays 0.
5. Overrun: three averages 0x10, 0x50, 0xA0 complete within one frame → frames "B 10\r\n" then "F A0\r\n"; `overrun`=1 and stays set.
6. Timing: AVG_LOG2=0, one strobe of 0xFF → `busy` high 2 CLK later. The frame lasts 6·42 − 1 CLK to the last stop-bit end, and `busy` falls 2 CLK after that (NEXT, then IDLE).
